// File: rtl/rgb_window_3x3.sv
// Streaming 3x3 RGB neighbourhood generator with two line memories and row shift registers.
// Optional `WINDOW_COORD_EN adds win_x/win_y window-centre coordinate outputs.
module rgb_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [23:0] in_pixel,
    output logic [7:0]  R_window00, R_window01, R_window02,
    output logic [7:0]  R_window10, R_window11, R_window12,
    output logic [7:0]  R_window20, R_window21, R_window22,
    output logic [7:0]  G_window00, G_window01, G_window02,
    output logic [7:0]  G_window10, G_window11, G_window12,
    output logic [7:0]  G_window20, G_window21, G_window22,
    output logic [7:0]  B_window00, B_window01, B_window02,
    output logic [7:0]  B_window10, B_window11, B_window12,
    output logic [7:0]  B_window20, B_window21, B_window22,
    output logic        start_conv,
    output logic        frame_done
`ifdef WINDOW_COORD_EN
    ,
    output logic [15:0] win_x,
    output logic [15:0] win_y
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t state_q, state_d;

    logic          accept, last_pix, emit;
    logic [CW-1:0] cur_col, col_d, col_q;
    logic [RW-1:0] cur_row, row_d, row_q;
    logic [23:0]   line1_mem [IMG_WIDTH];
    logic [23:0]   line2_mem [IMG_WIDTH];
    logic [23:0]   line1_rd, line2_rd;
    logic [2:0][2:0][23:0] sr_d, sr_q, win_d, win_q;
    logic          start_conv_d, start_conv_q;
    logic          frame_done_d, frame_done_q;
`ifdef WINDOW_COORD_EN
    logic [15:0]   win_x_d, win_x_q, win_y_d, win_y_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) state_d = last_pix ? S_IDLE : S_ACTIVE;
    end

    // An in_sof pixel always becomes (0,0), whether starting or aborting a frame.
    always_comb begin
        accept   = in_valid & (in_sof | (state_q == S_ACTIVE));
        cur_col  = in_sof ? '0 : col_q;
        cur_row  = in_sof ? '0 : row_q;
        last_pix = (cur_col == CW'(IMG_WIDTH - 1)) && (cur_row == RW'(IMG_HEIGHT - 1));
        emit     = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        sr_d         = sr_q;
        win_d        = win_q;
        start_conv_d = emit;
        frame_done_d = accept & last_pix;
        line1_rd     = line1_mem[cur_col];
        line2_rd     = line2_mem[cur_col];
`ifdef WINDOW_COORD_EN
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
`endif
        if (accept) begin
            if (last_pix) begin
                col_d = '0;
                row_d = '0;
            end else if (cur_col == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            for (int unsigned k = 0; k < 3; k++) begin
                sr_d[k][0] = sr_q[k][1];
                sr_d[k][1] = sr_q[k][2];
            end
            sr_d[0][2] = line2_rd;
            sr_d[1][2] = line1_rd;
            sr_d[2][2] = in_pixel;
        end
        if (emit) begin
            win_d = sr_d;
`ifdef WINDOW_COORD_EN
            win_x_d = 16'(cur_col) - 16'd1;
            win_y_d = 16'(cur_row) - 16'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            sr_q         <= '0;
            win_q        <= '0;
            start_conv_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef WINDOW_COORD_EN
            win_x_q      <= '0;
            win_y_q      <= '0;
`endif
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            sr_q         <= sr_d;
            win_q        <= win_d;
            start_conv_q <= start_conv_d;
            frame_done_q <= frame_done_d;
`ifdef WINDOW_COORD_EN
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
`endif
        end
    end

    // Line memories are deliberately not reset; rows 0-1 are never emitted.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            line2_mem[cur_col] <= line1_rd;
            line1_mem[cur_col] <= in_pixel;
        end
    end

    assign start_conv = start_conv_q;
    assign frame_done = frame_done_q;
`ifdef WINDOW_COORD_EN
    assign win_x = win_x_q;
    assign win_y = win_y_q;
`endif

    assign {R_window00, G_window00, B_window00} = win_q[0][0];
    assign {R_window01, G_window01, B_window01} = win_q[0][1];
    assign {R_window02, G_window02, B_window02} = win_q[0][2];
    assign {R_window10, G_window10, B_window10} = win_q[1][0];
    assign {R_window11, G_window11, B_window11} = win_q[1][1];
    assign {R_window12, G_window12, B_window12} = win_q[1][2];
    assign {R_window20, G_window20, B_window20} = win_q[2][0];
    assign {R_window21, G_window21, B_window21} = win_q[2][1];
    assign {R_window22, G_window22, B_window22} = win_q[2][2];

endmodule

// File: tb/tb_rgb_window_3x3.sv
// Directed bench for rgb_window_3x3 (8x6 image) with an image-level window model.
module tb_rgb_window_3x3;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_sof;
    logic [23:0] in_pixel;
    logic [7:0]  R_window00, R_window01, R_window02, R_window10, R_window11, R_window12;
    logic [7:0]  R_window20, R_window21, R_window22;
    logic [7:0]  G_window00, G_window01, G_window02, G_window10, G_window11, G_window12;
    logic [7:0]  G_window20, G_window21, G_window22;
    logic [7:0]  B_window00, B_window01, B_window02, B_window10, B_window11, B_window12;
    logic [7:0]  B_window20, B_window21, B_window22;
    logic        start_conv, frame_done;
`ifdef WINDOW_COORD_EN
    logic [15:0] win_x, win_y;
`endif

    rgb_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .R_window00(R_window00), .R_window01(R_window01), .R_window02(R_window02),
        .R_window10(R_window10), .R_window11(R_window11), .R_window12(R_window12),
        .R_window20(R_window20), .R_window21(R_window21), .R_window22(R_window22),
        .G_window00(G_window00), .G_window01(G_window01), .G_window02(G_window02),
        .G_window10(G_window10), .G_window11(G_window11), .G_window12(G_window12),
        .G_window20(G_window20), .G_window21(G_window21), .G_window22(G_window22),
        .B_window00(B_window00), .B_window01(B_window01), .B_window02(B_window02),
        .B_window10(B_window10), .B_window11(B_window11), .B_window12(B_window12),
        .B_window20(B_window20), .B_window21(B_window21), .B_window22(B_window22),
        .start_conv(start_conv), .frame_done(frame_done)
`ifdef WINDOW_COORD_EN
        , .win_x(win_x), .win_y(win_y)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             strobe;
        logic             done;
        logic             clr;
        logic             pin;
        logic [15:0]      x;
        logic [15:0]      y;
        logic [8:0][23:0] w;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   dut_strobes = 0;
    int   dut_dones = 0;

    logic [8:0][23:0] dut_w;
    assign dut_w = {R_window22, G_window22, B_window22, R_window21, G_window21, B_window21,
                    R_window20, G_window20, B_window20, R_window12, G_window12, B_window12,
                    R_window11, G_window11, B_window11, R_window10, G_window10, B_window10,
                    R_window02, G_window02, B_window02, R_window01, G_window01, B_window01,
                    R_window00, G_window00, B_window00};

    task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Image content: test-plan pattern, XORed with a per-frame salt to expose stale rows.
    function automatic logic [23:0] pixf(input logic [23:0] salt, input int r, input int c);
        logic [7:0] rr, gg, bb;
        rr = 8'(r * 16 + c);
        gg = 8'(8'hA0 + c);
        bb = 8'(8'h50 + r);
        return {rr, gg, bb} ^ salt;
    endfunction

    // Outputs expected after each clock, with hold-while-idle semantics.
    always begin
        exp_t             e;
        logic [8:0][23:0] hw;
        logic [15:0]      hx, hy;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.clr) begin
                hw = '0; hx = '0; hy = '0;
            end else if (e.strobe) begin
                hw = e.w; hx = e.x; hy = e.y;
            end
            if (start_conv === 1'b1) dut_strobes++;
            if (frame_done === 1'b1) dut_dones++;
            chk("start_conv", 216'(start_conv), 216'(e.strobe));
            chk("frame_done", 216'(frame_done), 216'(e.done));
            chk("window", dut_w, hw);
`ifdef WINDOW_COORD_EN
            chk("win_x", 216'(win_x), 216'(hx));
            chk("win_y", 216'(win_y), 216'(hy));
`endif
            if (e.pin) begin
                chk("pin_R00", 216'(R_window00), 216'(8'h00));
                chk("pin_R11", 216'(R_window11), 216'(8'h11));
                chk("pin_R22", 216'(R_window22), 216'(8'h22));
                chk("pin_G02", 216'(G_window02), 216'(8'hA2));
`ifdef WINDOW_COORD_EN
                chk("pin_win_x", 216'(win_x), 216'(16'd1));
                chk("pin_win_y", 216'(win_y), 216'(16'd1));
`endif
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic s, input logic [23:0] p,
                        input exp_t e);
        @(negedge clk);
        rst = r; in_valid = v; in_sof = s; in_pixel = p;
        q.push_back(e);
    endtask

    task automatic idle_step();
        exp_t e = '0;
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 24'($urandom), e);
    endtask

    // Sends frame pixels in raster order, stopping before pixel index stop_at.
    task automatic send_frame(input logic [23:0] salt, input int stop_at, input bit gaps,
                              input bit pin);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                exp_t e = '0;
                if (r * W + c >= stop_at) return;
                if (gaps && !(r == 0 && c == 0))
                    while ($urandom_range(0, 9) < 3) idle_step();
                if (r >= 2 && c >= 2) begin
                    e.strobe = 1'b1;
                    e.pin    = pin && r == 2 && c == 2;
                    e.x      = 16'(c - 1);
                    e.y      = 16'(r - 1);
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.w[i * 3 + j] = pixf(salt, r - 2 + i, c - 2 + j);
                end
                e.done = (r == H - 1 && c == W - 1);
                step(1'b0, 1'b1, (r == 0 && c == 0), pixf(salt, r, c), e);
            end
        end
    endtask

    task automatic count_check(input string name, input int s0, input int d0,
                               input int exp_s, input int exp_d);
        idle_step();
        @(posedge clk);
        #2;
        chk({name, "_strobes"}, 216'(dut_strobes - s0), 216'(exp_s));
        chk({name, "_dones"}, 216'(dut_dones - d0), 216'(exp_d));
    endtask

    initial begin
        exp_t e;
        int   s0, d0;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        e = '0; e.clr = 1'b1;
        step(1'b1, 1'b0, 1'b0, 24'h0, e);
        step(1'b1, 1'b1, 1'b0, 24'h123456, e);

        // Pixels before any start-of-frame are ignored.
        e = '0;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 24'($urandom), e);
        idle_step();

        // Continuous frame with pinned literals, then a back-to-back second frame.
        s0 = dut_strobes; d0 = dut_dones;
        send_frame(24'h000000, W * H, 1'b0, 1'b1);
        count_check("frameA", s0, d0, 24, 1);
        s0 = dut_strobes; d0 = dut_dones;
        send_frame(24'h3C5A69, W * H, 1'b0, 1'b0);
        send_frame(24'h000000, W * H, 1'b0, 1'b0);
        count_check("back2back", s0, d0, 48, 2);

        // Random idle gaps.
        s0 = dut_strobes; d0 = dut_dones;
        send_frame(24'h000000, W * H, 1'b1, 1'b0);
        count_check("gaps", s0, d0, 24, 1);

        // Abort at (3,4): old frame gives 8 windows and no frame_done.
        s0 = dut_strobes; d0 = dut_dones;
        send_frame(24'h0F0F0F, 3 * W + 4, 1'b0, 1'b0);
        send_frame(24'h000000, W * H, 1'b0, 1'b0);
        count_check("abort", s0, d0, 32, 1);

        // Reset in the middle of row 3, then a fresh frame.
        send_frame(24'h777777, 3 * W + 3, 1'b0, 1'b0);
        e = '0; e.clr = 1'b1;
        step(1'b1, 1'b1, 1'b0, 24'hABCDEF, e);
        s0 = dut_strobes; d0 = dut_dones;
        send_frame(24'h000000, W * H, 1'b0, 1'b0);
        count_check("after_rst", s0, d0, 24, 1);

        for (int k = 0; k < 3; k++) idle_step();
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rgb_window_3x3.md
# rgb_window_3x3

Streaming 3x3 neighbourhood generator for 24-bit RGB pixels, directly upstream of the 3x3 Gaussian convolution stage. Accepts one raster-order pixel per valid cycle, buffers the two previous image rows in internal line memories, and presents the nine R, G and B window bytes plus a `start_conv` strobe. Only windows lying fully inside the image are emitted; there is no border padding.

## Interface
- `IMG_WIDTH`, 640: pixels per row, ≥3.
- `IMG_HEIGHT`, 480: rows per frame, ≥3.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: pixel strobe; no backpressure exists.
- `in_sof` in 1: start of frame; qualified by `in_valid`; marks pixel (0,0).
- `in_pixel` in 24: {R[23:16], G[15:8], B[7:0]}.
- `R_window00..R_window22` out 8 each: R window; `rc` gives row/column within the window; `22` is the newest pixel.
- `G_window00..G_window22` out 8 each: G window, same layout.
- `B_window00..B_window22` out 8 each: B window, same layout.
- `start_conv` out 1: one-cycle strobe; the window outputs are valid.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame.

## Operation
- Two line memories, each `IMG_WIDTH` x 24 bits: `line1` holds row r-1 and `line2` holds row r-2. The write/read address is the column counter `col`.
- On an accepted pixel (r,c):
  - read `line1[c]` and `line2[c]`;
  - write `line2[c]` ← `line1[c]` and `line1[c]` ← `in_pixel`;
  - shift each of the three row shift registers (3 x 24 bits) left by one column.
- Window mapping: `x0y` = row r-2, `x1y` = row r-1, `x2y` = row r. `xy0` = column c-2 and `xy2` = column c.
- Windows are emitted only when r≥2 and c≥2, giving (`IMG_WIDTH`-2)·(`IMG_HEIGHT`-2) strobes per frame. Shift-register contents at c<2 are stale and are never emitted.
- Counters:
  - `col` wraps from `IMG_WIDTH`-1 to 0 and increments `row`.
  - `row` is cleared on `in_sof`.
- States:
  - S_IDLE: `in_valid` without `in_sof` is ignored. `in_valid & in_sof` sets col=row=0, accepts the pixel, and moves to S_ACTIVE.
  - S_ACTIVE: accepts pixels. Accepting the last pixel (row `IMG_HEIGHT`-1, col `IMG_WIDTH`-1) moves to S_IDLE and schedules `frame_done`.
- `in_sof` while in S_ACTIVE aborts the current frame. That pixel becomes (0,0); no `frame_done` is generated for the aborted frame.
- `in_valid` low stalls everything: counters, memories and shift registers hold, and `start_conv` stays low.
- Window outputs hold their last value while `start_conv` is low.

## Timing
- Latency: the window containing pixel (r,c) as `x22` appears one cycle after that pixel is accepted, with `start_conv` high for exactly that cycle.
- `frame_done` is high in the same cycle as the final `start_conv`.
- Throughput is one pixel per cycle sustained, including across row boundaries. There are no bubbles required at row or frame boundaries; `in_sof` may immediately follow the last pixel.
- Reset, whether idle or mid-frame:
  - all window outputs = 0, `start_conv` = 0, `frame_done` = 0;
  - counters = 0; state = S_IDLE.
  - Line memories are not cleared; this is harmless because rows 0–1 are never emitted.

## Configuration
- `WINDOW_COORD_EN` defined:
  - adds output `win_x` [15:0] and output `win_y` [15:0], the image coordinates of the window centre (c-1, r-1);
  - both are registered alongside the window and are 0 on reset.
- `WINDOW_COORD_EN` undefined: the ports and their registers are absent. All other behaviour is identical.

## Test plan
- Full frame, continuous stream:
  - stimulus: `IMG_WIDTH`=8, `IMG_HEIGHT`=6, pixel = {r·16+c, 8'hA0+c, 8'h50+r};
  - response: exactly 24 `start_conv` strobes. The first strobe comes one cycle after pixel (2,2), with R_window00=8'h00, R_window11=8'h11, R_window22=8'h22 and G_window02=8'hA2. `frame_done` coincides with the 24th strobe.
- Random `in_valid` gaps (30% idle cycles), same frame → identical 24 windows in the same order; `start_conv` never asserted during a gap.
- Pixels before any `in_sof` → ignored. A frame then starting with `in_sof` → first strobe after its pixel (2,2).
- `in_sof` issued at pixel (3,4) of a frame → no `frame_done` for the aborted frame. The restarted frame yields 24 windows with correct data and no contamination from the old rows.
- `rst` asserted mid-row-3 → next cycle: all outputs 0, `start_conv`=0. A following fresh frame → 24 correct windows.
- `WINDOW_COORD_EN` defined → first strobe has `win_x`=1, `win_y`=1; last strobe has `win_x`=6, `win_y`=4.
